// File: rtl/sll_log_ct.sv
// sll_log_ct: constant-time logical left shifter, one binary stage per cycle over a 2*SIZE-bit product
module sll_log_ct #(
  parameter int LOGSIZE = 8,
  localparam int SIZE = 2 ** LOGSIZE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [SIZE-1:0]    in,
  input  logic [LOGSIZE-1:0] shift,
  output logic [SIZE-1:0]    out,
  output logic [SIZE-1:0]    overflow,
  output logic               busy,
  output logic               done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t               state_q, state_d;
  logic [LOGSIZE-1:0]   stage_q, stage_d;
  logic [LOGSIZE-1:0]   sh_q, sh_d;
  logic [2*SIZE-1:0]    acc_q, acc_d;
  logic                 done_q, done_d;
  // next state: accept start in IDLE, then walk every stage so latency never depends on shift
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = SHIFT;
        stage_d = LOGSIZE'(1);
        sh_d    = shift;
        acc_d   = {{SIZE{1'b0}}, in};
      end
    end else begin
      for (int k = 0; k < LOGSIZE; k++)
        if (stage_q[k] && sh_q[k]) acc_d = acc_q << (1 << k);
      stage_d = stage_q << 1;
      if (stage_q[LOGSIZE-1]) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
  // state registers with synchronous reset that overrides start and aborts any operation
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end
  assign out      = acc_q[SIZE-1:0];
  assign overflow = acc_q[2*SIZE-1:SIZE];
  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
endmodule

// File: tb/tb_sll_log_ct.sv
// tb_sll_log_ct: scoreboard bench for the constant-time shifter at LOGSIZE=3
module tb_sll_log_ct;
  logic       clock = 1'b0;
  logic       reset, start;
  logic [7:0] in_v, out_v, ovf_v;
  logic [2:0] shift_v;
  logic       busy, done;
  logic [15:0] sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  sll_log_ct #(.LOGSIZE(3)) dut (
    .clock(clock), .reset(reset), .start(start), .in(in_v), .shift(shift_v),
    .out(out_v), .overflow(ovf_v), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // drive a start for one edge and push the reference 16-bit result; returns at the negedge of cycle 0
  task automatic launch(input logic [7:0] a, input logic [2:0] s);
    logic [15:0] r;
    r = {8'h00, a};
    r = r << s;
    sb.push_back(r);
    start = 1'b1; in_v = a; shift_v = s;
    @(negedge clock);
    start = 1'b0; in_v = $urandom; shift_v = $urandom;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; in_v = 8'hFF; shift_v = 3'd1;
    repeat (2) @(negedge clock);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out_v !== 8'h00 || ovf_v !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b out=%h ovf=%h, need 0 0 00 00", busy, done, out_v, ovf_v);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_op(input string name, input logic [7:0] a, input logic [2:0] s);
    logic [15:0] exp;
    launch(a, s);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s c0: busy=%b done=%b, need 1 0", name, busy, done);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      n_tests++;
      if (c < 3 && (busy !== 1'b1 || done !== 1'b0)) begin
        n_fail++;
        $display("FAIL %s c%0d: busy=%b done=%b, need 1 0", name, c, busy, done);
      end else if (c == 3 && (busy !== 1'b0 || done !== 1'b1)) begin
        n_fail++;
        $display("FAIL %s c3: busy=%b done=%b, need 0 1", name, busy, done);
      end
    end
    exp = sb.pop_front();
    n_tests++;
    if ({ovf_v, out_v} !== exp) begin
      n_fail++;
      $display("FAIL %s result: ovf/out=%h/%h, need %h/%h", name, ovf_v, out_v, exp[15:8], exp[7:0]);
    end
    @(negedge clock);
    n_tests++;
    if (done !== 1'b0 || {ovf_v, out_v} !== exp) begin
      n_fail++;
      $display("FAIL %s hold: done=%b ovf/out=%h/%h, need 0 %h/%h", name, done, ovf_v, out_v, exp[15:8], exp[7:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp;
    launch(8'hB5, 3'd7);
    repeat (3) @(negedge clock);
    exp = sb.pop_front();
    n_tests++;
    if (done !== 1'b1 || {ovf_v, out_v} !== exp) begin
      n_fail++;
      $display("FAIL b2b first: done=%b ovf/out=%h/%h, need 1 %h/%h", done, ovf_v, out_v, exp[15:8], exp[7:0]);
    end
    launch(8'hFF, 3'd1);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b accept: busy=%b done=%b, need 1 0", busy, done);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      n_tests++;
      if (done !== (c == 3)) begin
        n_fail++;
        $display("FAIL b2b second c%0d: done=%b, need %b", c, done, c == 3);
      end
    end
    exp = sb.pop_front();
    n_tests++;
    if ({ovf_v, out_v} !== exp) begin
      n_fail++;
      $display("FAIL b2b second result: ovf/out=%h/%h, need %h/%h", ovf_v, out_v, exp[15:8], exp[7:0]);
    end
    @(negedge clock);
  endtask

  task automatic test_ignored_start;
    logic [15:0] exp;
    int pulses;
    launch(8'hB5, 3'd3);
    @(negedge clock);
    start = 1'b1; in_v = 8'h01; shift_v = 3'd1;
    @(negedge clock);
    start = 1'b0;
    pulses = 0;
    for (int c = 3; c <= 9; c++) begin
      @(negedge clock);
      if (done === 1'b1) pulses++;
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore busy c%0d: busy=%b, need 0", c, busy);
      end
    end
    exp = sb.pop_front();
    n_tests++;
    if (pulses != 1 || {ovf_v, out_v} !== exp) begin
      n_fail++;
      $display("FAIL ignore: pulses=%0d ovf/out=%h/%h, need 1 %h/%h", pulses, ovf_v, out_v, exp[15:8], exp[7:0]);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    launch(8'hB5, 3'd3);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out_v !== 8'h00 || ovf_v !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b out=%h ovf=%h, need 0 0 00 00", busy, done, out_v, ovf_v);
    end
    pulses = 0;
    repeat (4) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid quiet: active cycles=%0d, need 0", pulses);
    end
    test_op("after_reset", 8'h81, 3'd2);
  endtask

  task automatic test_random;
    logic [15:0] exp;
    int lat, bad_lat, bad_res;
    bad_lat = 0; bad_res = 0;
    for (int i = 0; i < 1000; i++) begin
      launch(8'($urandom), 3'($urandom_range(0, 7)));
      lat = 0;
      while (done !== 1'b1 && lat < 10) begin
        @(negedge clock);
        lat++;
      end
      exp = sb.pop_front();
      n_tests++;
      if (lat != 3) begin
        n_fail++; bad_lat++;
        if (bad_lat < 5) $display("FAIL rand latency op%0d: %0d cycles, need 3", i, lat);
      end
      n_tests++;
      if ({ovf_v, out_v} !== exp) begin
        n_fail++; bad_res++;
        if (bad_res < 5) $display("FAIL rand result op%0d: ovf/out=%h/%h, need %h/%h", i, ovf_v, out_v, exp[15:8], exp[7:0]);
      end
      if (i % 3 == 0) @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_v = 8'h00; shift_v = 3'd0;
    @(negedge clock);
    test_reset;
    test_op("b5_sh3", 8'hB5, 3'd3);
    test_op("b5_sh0", 8'hB5, 3'd0);
    test_op("b5_sh7", 8'hB5, 3'd7);
    test_back_to_back;
    test_ignored_start;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sll_log_ct.md
SLL_LOG_CT -- requirements
Module: sll_log_ct

Interface
REQ-001 Parameter LOGSIZE, default 8: log2 of the data width; SIZE = 2^LOGSIZE.
REQ-002 The module SHALL provide port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL provide port start, input, 1 bit: request to begin an operation.
REQ-005 The module SHALL provide port in, input, SIZE bits: operand, sampled only on an accepted start.
REQ-006 The module SHALL provide port shift, input, LOGSIZE bits: left-shift amount 0..SIZE-1, sampled only on an accepted start.
REQ-007 The module SHALL provide port out, output, SIZE bits: low SIZE bits of in << shift, registered.
REQ-008 The module SHALL provide port overflow, output, SIZE bits: high SIZE bits of the 2*SIZE-bit product in << shift (the bits shifted out), registered.
REQ-009 The module SHALL provide port busy, output, 1 bit: operation in progress.
REQ-010 The module SHALL provide port done, output, 1 bit: one-cycle pulse marking that out and overflow are valid.

Function
REQ-011 The module SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 start SHALL be accepted only when busy=0; an accepted start SHALL register in, shift and a zero upper half, and SHALL enter SHIFT with stage pointer at stage 0 (one-hot, LOGSIZE bits).
REQ-013 In SHIFT, on each edge the module SHALL apply the current stage k: if registered shift[k]=1, {overflow,out} SHALL become {overflow,out} << 2^k, otherwise both SHALL hold; the pointer SHALL then advance to k+1.
REQ-014 Every operation SHALL take exactly LOGSIZE stage cycles regardless of the shift value, including shift=0 (constant-time; no early exit).
REQ-015 Latency: when start is accepted at edge E0, stages 0..LOGSIZE-1 SHALL be applied at edges E1..E_LOGSIZE; at edge E_LOGSIZE, done SHALL go to 1, busy SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-016 busy SHALL be 1 from edge E0 through the cycle before done is asserted.
REQ-017 done SHALL be high for exactly one cycle per operation.
REQ-018 out and overflow SHALL hold their final values after done until the next accepted start.
REQ-019 out and overflow are intermediate during SHIFT; consumers SHALL sample them only on done=1.
REQ-020 start while busy=1 SHALL be ignored with no effect on the running operation, and SHALL NOT be queued.
REQ-021 start asserted in the same cycle as done=1 SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-022 The 2*SIZE-bit shift SHALL be logical: zeros fill from the LSB; bits beyond 2*SIZE cannot occur because shift<SIZE.

Reset
REQ-023 When reset=1 at an edge, the module SHALL set busy=0, done=0, out=0, overflow=0, FSM=IDLE and the stage pointer to 0, overriding start.
REQ-024 A reset mid-operation SHALL abort the operation without asserting done; the next start after reset is released SHALL operate normally.

Verification (LOGSIZE=3, SIZE=8; cycle 0 is the cycle in which start is accepted)
REQ-025 The bench SHALL cover: in=8'hB5, shift=3 -> busy in cycles 1-2, done=1 in cycle 3 only, out=8'hA8, overflow=8'h05.
REQ-026 The bench SHALL cover: in=8'hB5, shift=0 -> done in cycle 3 (same latency), out=8'hB5, overflow=8'h00.
REQ-027 The bench SHALL cover: in=8'hB5, shift=7 -> out=8'h80, overflow=8'h5A; then in=8'hFF, shift=1 with start held in the done cycle -> second done exactly 3 cycles later, out=8'hFE, overflow=8'h01.
REQ-028 The bench SHALL cover: start in cycle 1 with in=8'h01, shift=1, during the shift=3 operation on 8'hB5 -> ignored; only one done pulse, result 8'hA8/8'h05.
REQ-029 The bench SHALL cover: reset=1 in cycle 2 of an operation -> next cycle busy=0, done=0, out=0, overflow=0, and no done pulse; then in=8'h81, shift=2 -> out=8'h04, overflow=8'h02.
REQ-030 The bench SHALL cover: randomized in/shift over 1000 operations compared against a 16-bit reference shift model, with a latency of exactly 3 checked on every operation.
